me_search_ctrl: RTL and testbench

Sequencing controller for the 8x8 SAD processing-element array in the motion-estimation engine. On `start` it preloads the reference window, then raster-scans RANGE_X x RANGE_Y candidate positions. For each position it drives the array's `compute_flag`/`pause`/`only_read` controls and tracks the array's pipelined SAD results. It reports the minimum SAD and its motion vector with a one-cycle `done` pulse.

---
 rtl/me_pkg.sv | 27 ++
 rtl/me_tag_pipe.sv | 85 ++++++++
 rtl/me_search_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_me_search_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/me_pkg.sv
`default_nettype none
// ============================================================================
// Module   : me_pkg
// Purpose  : Shared types and constants for the motion-estimation search
//            controller: FSM state encoding, default SAD width with its
//            all-ones value, and the motion-vector component width.
// Revision : 1.0 - initial release
// ============================================================================
package me_pkg;

    // Default SAD width and its all-ones value at that width.
    localparam int SAD_W_DEF = 14;
    localparam logic [SAD_W_DEF-1:0] SAD_MAX = '1;

    // Width of each motion-vector component (candidate column/row index).
    localparam int MV_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_SCAN  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } me_state_e;

endpackage : me_pkg
`default_nettype wire

// File: rtl/me_tag_pipe.sv
`default_nettype none
// ============================================================================
// Module   : me_tag_pipe
// Purpose  : PIPE_LAT-deep shift register of candidate tags {valid, x, y}
//            that mirrors the PE array latency, so each SAD leaving the array
//            can be matched to the candidate position that produced it.
// Ports    : clk, rst (async active-low)
//            clr        - synchronous flush of all stages
//            shift_en   - advance the pipe by one stage
//            push_*     - tag entering stage 0 on a shift
//            tail_*     - oldest stage (tag matching the current SAD)
//            any_valid  - some stage holds a valid tag
//            head_valid - some non-tail stage holds a valid tag
// Revision : 1.0 - initial release
// ============================================================================
module me_tag_pipe #(
    parameter int PIPE_LAT = 2,
    parameter int TAG_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             shift_en,
    input  logic             push_valid,
    input  logic [TAG_W-1:0] push_x,
    input  logic [TAG_W-1:0] push_y,
    output logic             tail_valid,
    output logic [TAG_W-1:0] tail_x,
    output logic [TAG_W-1:0] tail_y,
    output logic             any_valid,
    output logic             head_valid
);

    logic [PIPE_LAT-1:0]            valid_q, valid_d;
    logic [PIPE_LAT-1:0][TAG_W-1:0] x_q, x_d;
    logic [PIPE_LAT-1:0][TAG_W-1:0] y_q, y_d;

    always_comb begin
        valid_d = valid_q;
        x_d     = x_q;
        y_d     = y_q;
        if (clr) begin
            valid_d = '0;
            x_d     = '0;
            y_d     = '0;
        end else if (shift_en) begin
            valid_d[0] = push_valid;
            x_d[0]     = push_x;
            y_d[0]     = push_y;
            for (int i = 1; i < PIPE_LAT; i++) begin
                valid_d[i] = valid_q[i-1];
                x_d[i]     = x_q[i-1];
                y_d[i]     = y_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
            x_q     <= '0;
            y_q     <= '0;
        end else begin
            valid_q <= valid_d;
            x_q     <= x_d;
            y_q     <= y_d;
        end
    end

    // head_valid tells the controller whether anything would remain valid
    // after the tail is consumed on the next shift.
    always_comb begin
        head_valid = 1'b0;
        for (int i = 0; i < PIPE_LAT - 1; i++) begin
            head_valid = head_valid | valid_q[i];
        end
    end

    assign any_valid  = |valid_q;
    assign tail_valid = valid_q[PIPE_LAT-1];
    assign tail_x     = x_q[PIPE_LAT-1];
    assign tail_y     = y_q[PIPE_LAT-1];

endmodule : me_tag_pipe
`default_nettype wire

// File: rtl/me_search_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : me_search_ctrl
// Purpose  : Sequencer for the 8x8 SAD PE array. Preloads the reference
//            window, raster-scans RANGE_X x RANGE_Y candidates, tracks the
//            minimum SAD coming back from the array and reports it with its
//            motion vector on a one-cycle done pulse.
// Ports    : clk, rst (async active-low)
//            start        - begin a search (IDLE only)
//            ref_valid    - reference data available; low freezes progress
//            pe_result    - SAD from the PE array
//            compute_flag - array compute enable (SCAN)
//            pause        - array freeze (!ref_valid while active)
//            only_read    - array preload mode (LOAD)
//            busy         - search in progress, through the DONE cycle
//            done         - one-cycle pulse, best_* valid
//            best_sad, best_mv_x, best_mv_y - result of last completed search
// Revision : 1.0 - initial release
// ============================================================================
module me_search_ctrl
    import me_pkg::*;
#(
    parameter int SAD_W    = SAD_W_DEF,
    parameter int RANGE_X  = 16,
    parameter int RANGE_Y  = 16,
    parameter int LOAD_CYC = 8,
    parameter int PIPE_LAT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             ref_valid,
    input  logic [SAD_W-1:0] pe_result,
    output logic             compute_flag,
    output logic             pause,
    output logic             only_read,
    output logic             busy,
    output logic             done,
    output logic [SAD_W-1:0] best_sad,
    output logic [MV_W-1:0]  best_mv_x,
    output logic [MV_W-1:0]  best_mv_y
);

    localparam int               LCW         = (LOAD_CYC > 1) ? $clog2(LOAD_CYC) : 1;
    localparam logic [LCW-1:0]   C_LOAD_LAST = LCW'(LOAD_CYC - 1);
    localparam logic [MV_W-1:0]  C_X_LAST    = MV_W'(RANGE_X - 1);
    localparam logic [MV_W-1:0]  C_Y_LAST    = MV_W'(RANGE_Y - 1);
    localparam logic [SAD_W-1:0] C_SAD_INIT  = {SAD_W{1'b1}};

    me_state_e        state_q, state_d;
    logic [LCW-1:0]   load_cnt_q, load_cnt_d;
    logic [MV_W-1:0]  x_q, x_d, y_q, y_d;
    logic [SAD_W-1:0] min_q, min_d;
    logic [MV_W-1:0]  min_x_q, min_x_d, min_y_q, min_y_d;
    logic [SAD_W-1:0] best_sad_q, best_sad_d;
    logic [MV_W-1:0]  best_x_q, best_x_d, best_y_q, best_y_d;

    logic             accepted;
    logic             pipe_clr;
    logic             tail_valid, any_valid, head_valid;
    logic [MV_W-1:0]  tail_x, tail_y;

    assign accepted = (state_q != ST_IDLE) && ref_valid;

    me_tag_pipe #(
        .PIPE_LAT (PIPE_LAT),
        .TAG_W    (MV_W)
    ) u_tag_pipe (
        .clk        (clk),
        .rst        (rst),
        .clr        (pipe_clr),
        .shift_en   (accepted),
        .push_valid (state_q == ST_SCAN),
        .push_x     (x_q),
        .push_y     (y_q),
        .tail_valid (tail_valid),
        .tail_x     (tail_x),
        .tail_y     (tail_y),
        .any_valid  (any_valid),
        .head_valid (head_valid)
    );

    always_comb begin
        state_d    = state_q;
        load_cnt_d = load_cnt_q;
        x_d        = x_q;
        y_d        = y_q;
        min_d      = min_q;
        min_x_d    = min_x_q;
        min_y_d    = min_y_q;
        best_sad_d = best_sad_q;
        best_x_d   = best_x_q;
        best_y_d   = best_y_q;
        pipe_clr   = 1'b0;

        // Strictly-less keeps the earliest raster candidate on ties, and an
        // all-ones SAD can never displace the all-ones initial minimum.
        if (accepted && tail_valid && (pe_result < min_q)) begin
            min_d   = pe_result;
            min_x_d = tail_x;
            min_y_d = tail_y;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_LOAD;
                    load_cnt_d = '0;
                    x_d        = '0;
                    y_d        = '0;
                    pipe_clr   = 1'b1;
                    min_d      = C_SAD_INIT;
                    min_x_d    = '0;
                    min_y_d    = '0;
                end
            end
            ST_LOAD: begin
                if (accepted) begin
                    if (load_cnt_q == C_LOAD_LAST) begin
                        state_d = ST_SCAN;
                    end else begin
                        load_cnt_d = load_cnt_q + 1'b1;
                    end
                end
            end
            ST_SCAN: begin
                if (accepted) begin
                    if (x_q == C_X_LAST) begin
                        x_d = '0;
                        if (y_q == C_Y_LAST) begin
                            state_d = ST_DRAIN;
                        end else begin
                            y_d = y_q + 1'b1;
                        end
                    end else begin
                        x_d = x_q + 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                // Leave once the tail compare this cycle is the last valid
                // tag, so best_* is already updated in the DONE cycle.
                if (!any_valid || (accepted && !head_valid)) begin
                    state_d    = ST_DONE;
                    best_sad_d = min_d;
                    best_x_d   = min_x_d;
                    best_y_d   = min_y_d;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            load_cnt_q <= '0;
            x_q        <= '0;
            y_q        <= '0;
            min_q      <= '0;
            min_x_q    <= '0;
            min_y_q    <= '0;
            best_sad_q <= '0;
            best_x_q   <= '0;
            best_y_q   <= '0;
        end else begin
            state_q    <= state_d;
            load_cnt_q <= load_cnt_d;
            x_q        <= x_d;
            y_q        <= y_d;
            min_q      <= min_d;
            min_x_q    <= min_x_d;
            min_y_q    <= min_y_d;
            best_sad_q <= best_sad_d;
            best_x_q   <= best_x_d;
            best_y_q   <= best_y_d;
        end
    end

    assign busy         = (state_q != ST_IDLE);
    assign done         = (state_q == ST_DONE);
    assign compute_flag = (state_q == ST_SCAN);
    assign only_read    = (state_q == ST_LOAD);
    assign pause        = busy && !ref_valid;
    assign best_sad     = best_sad_q;
    assign best_mv_x    = best_x_q;
    assign best_mv_y    = best_y_q;

endmodule : me_search_ctrl
`default_nettype wire

// File: tb/tb_me_search_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_me_search_ctrl
// Purpose  : Self-checking bench for me_search_ctrl. A 16x16 instance and a
//            1x1 instance share clock, reset and array-side inputs. The model
//            tracks only the number of accepted cycles since start and derives
//            the expected phase, array SAD and final best result from it.
// Revision : 1.0 - initial release
// ============================================================================
module tb_me_search_ctrl;

    localparam int L = 8;   // LOAD_CYC
    localparam int P = 2;   // PIPE_LAT

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start_v = 1'b0;
    logic        ref_valid = 1'b0;
    logic [13:0] pe_result = '0;
    int          sel = 0;

    wire start0 = start_v && (sel == 0);
    wire start1 = start_v && (sel == 1);

    wire [1:0]       cf, pz, orr, bz, dn;
    wire [1:0][13:0] bs;
    wire [1:0][7:0]  bx, by;

    int errors = 0;
    int checks = 0;
    int eb_sad [2];
    int eb_x   [2];
    int eb_y   [2];

    me_search_ctrl #(.SAD_W(14), .RANGE_X(16), .RANGE_Y(16), .LOAD_CYC(L), .PIPE_LAT(P)) u_dut_main (
        .clk(clk), .rst(rst), .start(start0), .ref_valid(ref_valid), .pe_result(pe_result),
        .compute_flag(cf[0]), .pause(pz[0]), .only_read(orr[0]), .busy(bz[0]), .done(dn[0]),
        .best_sad(bs[0]), .best_mv_x(bx[0]), .best_mv_y(by[0])
    );

    me_search_ctrl #(.SAD_W(14), .RANGE_X(1), .RANGE_Y(1), .LOAD_CYC(L), .PIPE_LAT(P)) u_dut_one (
        .clk(clk), .rst(rst), .start(start1), .ref_valid(ref_valid), .pe_result(pe_result),
        .compute_flag(cf[1]), .pause(pz[1]), .only_read(orr[1]), .busy(bz[1]), .done(dn[1]),
        .best_sad(bs[1]), .best_mv_x(bx[1]), .best_mv_y(by[1])
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int sad_of(input int mode, input int x, input int y);
        case (mode)
            0:       return ((x > 5) ? x - 5 : 5 - x) + ((y > 9) ? y - 9 : 9 - y);
            1:       return 100;
            2:       return 'h3FFE;
            default: return 'h3FFF;
        endcase
    endfunction

    task automatic chk_best(input string nm, input int s);
        chk({nm, "_best_sad"}, 32'(bs[s]), eb_sad[s]);
        chk({nm, "_best_x"},   32'(bx[s]), eb_x[s]);
        chk({nm, "_best_y"},   32'(by[s]), eb_y[s]);
    endtask

    // One search on instance sel_i. d*a/d*n: drop ref_valid for d*n cycles
    // when the accepted count reaches d*a. abort_at >= 0 pulls reset there.
    task automatic run_search(input int sel_i, input int mode, input int d1a, input int d1n,
                              input int d2a, input int d2n, input int abort_at,
                              input bit start_mid, input bit start_at_done, input int exp_lat);
        int rx, ry, n, a, drop_left, lat, ph, mb, mx, my;
        bit d1_used, d2_used, fin;
        sel = sel_i;
        rx  = (sel_i == 0) ? 16 : 1;
        ry  = (sel_i == 0) ? 16 : 1;
        n   = rx * ry;
        mb = 'h3FFF; mx = 0; my = 0;
        for (int k = 0; k < n; k++) begin
            if (sad_of(mode, k % rx, k / rx) < mb) begin
                mb = sad_of(mode, k % rx, k / rx);
                mx = k % rx;
                my = k / rx;
            end
        end

        @(negedge clk);
        start_v = 1'b1; ref_valid = 1'b1; pe_result = '0;
        #1;
        chk("start_cycle_busy", 32'(bz[sel]), 0);
        chk("start_cycle_cf",   32'(cf[sel]), 0);
        @(posedge clk);

        a = 0; drop_left = 0; d1_used = 0; d2_used = 0; fin = 0; lat = -1;
        for (int c = 1; c < 2000 && !fin; c++) begin
            @(negedge clk);
            if (a >= L + n + P)  ph = 4;
            else if (a >= L + n) ph = 3;
            else if (a >= L)     ph = 2;
            else                 ph = 1;
            start_v = (start_mid && c == 5) || (start_at_done && ph == 4);
            if (!d1_used && d1n > 0 && a == d1a) begin drop_left = d1n; d1_used = 1; end
            if (!d2_used && d2n > 0 && a == d2a) begin drop_left = d2n; d2_used = 1; end
            ref_valid = (drop_left == 0);
            if (drop_left > 0) drop_left--;
            pe_result = (ref_valid && a >= L + P && a < L + P + n)
                      ? 14'(sad_of(mode, (a - L - P) % rx, (a - L - P) / rx)) : 14'd0;
            if (abort_at >= 0 && a == abort_at) begin
                rst = 1'b0;
                #1;
                chk("rst_cf",    32'(cf[sel]),  0);
                chk("rst_pause", 32'(pz[sel]),  0);
                chk("rst_only",  32'(orr[sel]), 0);
                chk("rst_busy",  32'(bz[sel]),  0);
                chk("rst_done",  32'(dn[sel]),  0);
                for (int s = 0; s < 2; s++) begin
                    eb_sad[s] = 0; eb_x[s] = 0; eb_y[s] = 0;
                end
                chk_best("rst", sel);
                @(negedge clk);
                rst = 1'b1; start_v = 1'b0;
                return;
            end
            #1;
            chk("busy",         32'(bz[sel]),  1);
            chk("compute_flag", 32'(cf[sel]),  32'(ph == 2));
            chk("only_read",    32'(orr[sel]), 32'(ph == 1));
            chk("pause",        32'(pz[sel]),  32'(!ref_valid));
            chk("done",         32'(dn[sel]),  32'(ph == 4));
            if (ph == 4) begin
                eb_sad[sel] = mb; eb_x[sel] = mx; eb_y[sel] = my;
                lat = c; fin = 1;
            end
            chk_best("run", sel);
            @(posedge clk);
            if (ref_valid && ph != 4) a++;
        end
        start_v = 1'b0;
        chk("done_seen", 32'(fin), 1);
        chk("latency", lat, exp_lat);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            ref_valid = 1'b1;
            #1;
            chk("after_busy", 32'(bz[sel]), 0);
            chk("after_done", 32'(dn[sel]), 0);
            chk_best("hold", sel);
        end
    endtask

    initial begin
        for (int s = 0; s < 2; s++) begin
            eb_sad[s] = 0; eb_x[s] = 0; eb_y[s] = 0;
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            chk("reset_busy",  32'(bz[s]),  0);
            chk("reset_cf",    32'(cf[s]),  0);
            chk("reset_only",  32'(orr[s]), 0);
            chk("reset_pause", 32'(pz[s]),  0);
            chk("reset_done",  32'(dn[s]),  0);
            chk_best("reset", s);
        end
        @(negedge clk);
        rst = 1'b1;

        // Cone SAD |x-5|+|y-9|, no stalls: 268 cycles start..done inclusive.
        run_search(0, 0, 0, 0, 0, 0, -1, 1'b0, 1'b0, 267);
        chk("t1_lit_sad", 32'(bs[0]), 0);
        chk("t1_lit_x",   32'(bx[0]), 5);
        chk("t1_lit_y",   32'(by[0]), 9);

        // Constant SAD: tie keeps the first raster candidate.
        run_search(0, 1, 0, 0, 0, 0, -1, 1'b0, 1'b0, 267);
        chk("t2_lit_sad", 32'(bs[0]), 100);
        chk("t2_lit_x",   32'(bx[0]), 0);
        chk("t2_lit_y",   32'(by[0]), 0);

        // 3 stall cycles in LOAD, 5 mid-SCAN: 8 cycles later, same result.
        run_search(0, 0, 3, 3, L + 100, 5, -1, 1'b0, 1'b0, 275);
        chk("t3_lit_sad", 32'(bs[0]), 0);
        chk("t3_lit_x",   32'(bx[0]), 5);
        chk("t3_lit_y",   32'(by[0]), 9);

        // Single candidate, start during busy and during DONE both ignored.
        run_search(1, 2, 0, 0, 0, 0, -1, 1'b1, 1'b1, 12);
        chk("t4_lit_sad", 32'(bs[1]), 'h3FFE);
        chk("t4_lit_x",   32'(bx[1]), 0);

        // All-ones SAD never updates the minimum.
        run_search(1, 3, 0, 0, 0, 0, -1, 1'b0, 1'b0, 12);
        chk("t5_lit_sad", 32'(bs[1]), 'h3FFF);
        chk("t5_lit_y",   32'(by[1]), 0);

        // Reset mid-SCAN, then a fresh search completes normally.
        run_search(0, 0, 0, 0, 0, 0, L + 20, 1'b0, 1'b0, 0);
        chk("t6_other_inst_cleared", 32'(bs[1]), 0);
        run_search(0, 0, 0, 0, 0, 0, -1, 1'b0, 1'b0, 267);
        chk("t6_lit_sad", 32'(bs[0]), 0);
        chk("t6_lit_x",   32'(bx[0]), 5);
        chk("t6_lit_y",   32'(by[0]), 9);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_me_search_ctrl
`default_nettype wire
